ahb_slave_arbiter: RTL

Per-slave arbiter in the AHB_Gen multi-layer interconnect, directly downstream of each master's address decoder. It collects the `hreq` bit that every master's decoder raises for this slave and grants the slave to one master at a time, round-robin, holding ownership for the whole burst. It produces the slave select plus the address-phase and data-phase master-mux selects. One instance exists per slave port.

---
 rtl/AHB_package.sv | 38 +++
 rtl/ahb_rr_picker.sv | 42 ++++
 rtl/ahb_slave_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/AHB_package.sv
// AHB_package: shared AHB transfer/burst types for the interconnect arbiters.
//   htrans_type    - IDLE / BUSY / NONSEQ / SEQ transfer type
//   hburst_type    - SINGLE .. INCR16 burst type
//   burst_beats_m1 - number of beats in a burst minus one (0 for SINGLE/INCR)
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_type;

    // Undefined-length INCR loads 0 like SINGLE; its lock is held by the
    // transfer types, not the counter.
    function automatic logic [3:0] burst_beats_m1(input hburst_type burst);
        logic [3:0] beats;
        case (burst)
            WRAP4, INCR4:   beats = 4'd3;
            WRAP8, INCR8:   beats = 4'd7;
            WRAP16, INCR16: beats = 4'd15;
            default:        beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: combinational rotate-priority select. Searches hreq starting
// at rr_ptr, wrapping modulo MASTER_NUM, and returns the first requester.
//   hreq       in  - request vector
//   rr_ptr     in  - index where the search starts (tie to 0 for fixed priority)
//   win_onehot out - one-hot winner, zero when nobody requests
//   win_idx    out - index of the winner, 0 when nobody requests
//   win_valid  out - some master requests
module ahb_rr_picker #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned MST_IDX_W  = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] hreq,
    input  logic [MST_IDX_W-1:0]  rr_ptr,
    output logic [MASTER_NUM-1:0] win_onehot,
    output logic [MST_IDX_W-1:0]  win_idx,
    output logic                  win_valid
);

    int unsigned          pos;
    logic [MST_IDX_W-1:0] sel;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        pos        = 0;
        sel        = '0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            pos = 32'(rr_ptr) + i;
            if (pos >= MASTER_NUM) begin
                pos = pos - MASTER_NUM;
            end
            sel = MST_IDX_W'(pos);
            if (!win_valid && hreq[sel]) begin
                win_valid       = 1'b1;
                win_onehot[sel] = 1'b1;
                win_idx         = sel;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter: per-slave arbiter of the multi-layer interconnect.
// Grants the slave to one master at a time (round-robin) and keeps the grant
// for a whole burst. Define AHB_ARB_FIXED_PRIO_EN for lowest-index-wins
// priority instead of round-robin (burst locking unchanged).
//   hclk, hreset  in  - clock, asynchronous active-high reset
//   hreq          in  - per-master decoder request for this slave
//   htrans/hburst in  - per-master transfer and burst type
//   hready        in  - hreadyout of this slave
//   hgrant        out - registered one-hot owner (or zero)
//   hsel          out - address-phase slave select
//   haddr_mst_sel out - owner index for the address/control mux
//   hdata_mst_sel out - data-phase master index for wdata mux / response routing
//   hdata_valid   out - an accepted transfer is in its data phase
module ahb_slave_arbiter
    import AHB_package::*;
#(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned MST_IDX_W  = $clog2(MASTER_NUM)
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [MASTER_NUM-1:0] hreq,
    input  htrans_type            htrans [MASTER_NUM],
    input  hburst_type            hburst [MASTER_NUM],
    input  logic                  hready,
    output logic [MASTER_NUM-1:0] hgrant,
    output logic                  hsel,
    output logic [MST_IDX_W-1:0]  haddr_mst_sel,
    output logic [MST_IDX_W-1:0]  hdata_mst_sel,
    output logic                  hdata_valid
);

    logic [MASTER_NUM-1:0] hgrant_q, hgrant_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  lock_q, lock_d;
    logic [MST_IDX_W-1:0]  dsel_q;
    logic                  dvalid_q;

    logic [MST_IDX_W-1:0]  owner;
    logic                  owner_valid;
    htrans_type            own_trans;
    hburst_type            own_burst;
    logic                  own_req;
    logic                  accept, acc_nonseq, acc_seq, arb;

    logic [MASTER_NUM-1:0] win_onehot;
    logic [MST_IDX_W-1:0]  win_idx;
    logic                  win_valid;
    logic [MST_IDX_W-1:0]  pick_ptr;

    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            if (hgrant_q[i]) begin
                owner = MST_IDX_W'(i);
            end
        end
    end

    assign owner_valid = |hgrant_q;
    assign own_trans   = htrans[owner];
    assign own_burst   = hburst[owner];
    assign own_req     = hreq[owner];

    assign hsel       = owner_valid & own_req & (own_trans != IDLE);
    assign accept     = hsel & hready & ((own_trans == NONSEQ) | (own_trans == SEQ));
    assign acc_nonseq = accept & (own_trans == NONSEQ);
    assign acc_seq    = accept & (own_trans == SEQ);

    ahb_rr_picker #(
        .MASTER_NUM(MASTER_NUM),
        .MST_IDX_W (MST_IDX_W)
    ) u_picker (
        .hreq      (hreq),
        .rr_ptr    (pick_ptr),
        .win_onehot(win_onehot),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // The arbitration decision looks at the lock value this cycle produces,
    // so the first beat of a fixed burst is already protected and the last
    // beat's edge hands the slave over with no dead cycle.
    always_comb begin
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        hgrant_d = hgrant_q;
        if (acc_nonseq) begin
            cnt_d  = burst_beats_m1(own_burst);
            lock_d = (own_burst != SINGLE);
        end else if (acc_seq) begin
            if (cnt_q == 4'd1) begin
                lock_d = 1'b0;
            end
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (hready && owner_valid && own_trans == IDLE) begin
            cnt_d  = 4'd0;
            lock_d = 1'b0;
        end

        arb = hready & (~owner_valid | ~own_req | (own_trans == IDLE) | ~lock_d);
        if (arb) begin
            hgrant_d = win_valid ? win_onehot : '0;
            cnt_d    = 4'd0;
            lock_d   = 1'b0;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hgrant_q <= '0;
            cnt_q    <= '0;
            lock_q   <= 1'b0;
            dsel_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            hgrant_q <= hgrant_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            if (hready) begin
                dsel_q   <= owner;
                dvalid_q <= accept;
            end
        end
    end

`ifdef AHB_ARB_FIXED_PRIO_EN
    logic unused_pick;
    assign unused_pick = ^win_idx;
    assign pick_ptr    = '0;
`else
    logic [MST_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (arb && win_valid) begin
            rr_ptr_d = (win_idx == MST_IDX_W'(MASTER_NUM - 1)) ? '0
                                                                : win_idx + MST_IDX_W'(1);
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign pick_ptr = rr_ptr_q;
`endif

    assign hgrant        = hgrant_q;
    assign haddr_mst_sel = owner;
    assign hdata_mst_sel = dsel_q;
    assign hdata_valid   = dvalid_q;

endmodule
